// File: rtl/fifo_pkg.sv
// Shared defaults and the word type for the synchronous show-ahead FIFO.
package fifo_pkg;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 16;

  typedef logic [DATA_W-1:0] word_t;

endpackage

// File: rtl/fifo_mem.sv
// DEPTH x DATA_W register array: one synchronous write port, one combinational read port.
module fifo_mem
  import fifo_pkg::*;
#(
  parameter int DATA_W = fifo_pkg::DATA_W,
  parameter int DEPTH  = fifo_pkg::DEPTH,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  // Storage is deliberately left unreset; the pointers decide what is valid.
  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/fifo.sv
// Single-clock FIFO with a registered first-word-fall-through output on dout.
module fifo
  import fifo_pkg::*;
#(
  parameter int DATA_W = fifo_pkg::DATA_W,
  parameter int DEPTH  = fifo_pkg::DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] di,
  input  logic              wen,
  output logic [DATA_W-1:0] dout,
  input  logic              ren
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0]  rd_ptr_reg, rd_ptr_next;
  logic [PTR_W-1:0]  wr_ptr_reg, wr_ptr_next;
  logic [CNT_W-1:0]  count_reg, count_next;
  logic [DATA_W-1:0] dout_reg, dout_next;
  logic [PTR_W-1:0]  ahead_addr;
  logic [DATA_W-1:0] ahead_data;
  logic              empty, full, rd_acc, wr_acc;

  // The word behind the head is fetched early so a pop can refill dout in one edge.
  assign ahead_addr = rd_ptr_reg + PTR_W'(1);

  fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .clk     (clk),
    .wr_en   (wr_acc),
    .wr_addr (wr_ptr_reg),
    .wr_data (di),
    .rd_addr (ahead_addr),
    .rd_data (ahead_data)
  );

  always_comb begin
    empty       = (count_reg == '0);
    full        = (count_reg == CNT_W'(DEPTH));
    rd_acc      = ren & ~empty;
    // A pop in the same edge frees the slot, so a full FIFO still accepts.
    wr_acc      = wen & (~full | rd_acc);
    rd_ptr_next = rd_ptr_reg;
    wr_ptr_next = wr_ptr_reg;
    count_next  = count_reg;
    dout_next   = dout_reg;

    if (rd_acc) rd_ptr_next = rd_ptr_reg + PTR_W'(1);
    if (wr_acc) wr_ptr_next = wr_ptr_reg + PTR_W'(1);

    case ({wr_acc, rd_acc})
      2'b10:   count_next = count_reg + CNT_W'(1);
      2'b01:   count_next = count_reg - CNT_W'(1);
      default: count_next = count_reg;
    endcase

    if (empty && wr_acc) begin
      dout_next = di;
    end else if (rd_acc && count_reg >= CNT_W'(2)) begin
      dout_next = ahead_data;
    end else if (rd_acc && wr_acc) begin
      // Last stored word popped while a new one arrives: bypass it straight to dout.
      dout_next = di;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
      dout_reg   <= '0;
    end else begin
      rd_ptr_reg <= rd_ptr_next;
      wr_ptr_reg <= wr_ptr_next;
      count_reg  <= count_next;
      dout_reg   <= dout_next;
    end
  end

  assign dout = dout_reg;

endmodule

// File: tb/tb_fifo.sv
// Scoreboard bench for fifo: expected words queued on accepted writes, compared on pops.
module tb_fifo;
  import fifo_pkg::*;

  logic  clk = 1'b0;
  logic  rst = 1'b1;
  word_t di  = '0;
  logic  wen = 1'b0;
  logic  ren = 1'b0;
  word_t dout;

  int n_checks = 0;
  int n_pass   = 0;

  word_t sb_q[$];
  word_t model_dout = '0;
  int    model_rd   = 0;
  int    model_wr   = 0;

  fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk  (clk),
    .rst  (rst),
    .di   (di),
    .wen  (wen),
    .dout (dout),
    .ren  (ren)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) $display("FAIL %s: got %h expected %h", tag, obs, exp);
    else n_pass++;
  endtask

  // One clock of stimulus; called just after a rising edge.
  task automatic do_cycle(input logic w, input word_t d, input logic r);
    bit    rd_ok, wr_ok;
    word_t exp;
    wen   = w;
    di    = d;
    ren   = r;
    rd_ok = r && (sb_q.size() > 0);
    wr_ok = w && ((sb_q.size() < DEPTH) || rd_ok);
    if (rd_ok) begin
      exp = sb_q.pop_front();
      check_eq("pop_head", dout, exp);
      model_rd = (model_rd + 1) % DEPTH;
    end
    if (wr_ok) begin
      sb_q.push_back(d);
      model_wr = (model_wr + 1) % DEPTH;
    end
    @(posedge clk);
    #1;
    if (sb_q.size() > 0) model_dout = sb_q[0];
    $display("txn wen=%0b di=%h ren=%0b -> dout=%h stored=%0d", w, d, r, dout, sb_q.size());
    check_eq("dout_after", dout, model_dout);
    wen = 1'b0;
    ren = 1'b0;
  endtask

  task automatic check_state(input string tag);
    check_eq({tag, "_count"}, 32'(dut.count_reg), 32'(sb_q.size()));
  endtask

  initial begin
    repeat (5) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state and underflow right after reset.
    check_eq("reset_dout", dout, 32'h0);
    do_cycle(1'b0, '0, 1'b1);
    check_eq("reset_ren_dout", dout, 32'h0);

    // Ordered transfer with spaced pops.
    for (int i = 0; i < 5; i++) do_cycle(1'b1, 32'hA000_0000 + 32'(i), 1'b0);
    do_cycle(1'b0, '0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      check_eq("ordered_head", dout, 32'hA000_0000 + 32'(i));
      do_cycle(1'b0, '0, 1'b1);
      do_cycle(1'b0, '0, 1'b0);
      do_cycle(1'b0, '0, 1'b0);
    end

    // Overflow: 17th word is dropped.
    for (int i = 0; i < 17; i++) do_cycle(1'b1, word_t'(i), 1'b0);
    check_state("full");
    for (int i = 0; i < 16; i++) do_cycle(1'b0, '0, 1'b1);
    do_cycle(1'b0, '0, 1'b0);
    check_eq("hold_15", dout, 32'd15);

    // Underflow leaves dout and pointers alone.
    do_cycle(1'b0, '0, 1'b1);
    check_eq("underflow_dout", dout, 32'd15);
    check_eq("underflow_rd_ptr", 32'(dut.rd_ptr_reg), 32'(model_rd));
    check_eq("underflow_wr_ptr", 32'(dut.wr_ptr_reg), 32'(model_wr));
    do_cycle(1'b1, 32'h55, 1'b0);
    check_eq("after_underflow", dout, 32'h55);
    do_cycle(1'b0, '0, 1'b1);

    // Simultaneous push/pop with a single stored word.
    do_cycle(1'b1, 32'h11, 1'b0);
    do_cycle(1'b1, 32'h22, 1'b1);
    check_eq("simul_dout", dout, 32'h22);
    check_state("simul_one");
    do_cycle(1'b0, '0, 1'b1);

    // Simultaneous push/pop while full.
    for (int i = 0; i < 16; i++) do_cycle(1'b1, 32'h100 + 32'(i), 1'b0);
    for (int i = 0; i < 4; i++) begin
      do_cycle(1'b1, 32'h200 + 32'(i), 1'b1);
      check_state("simul_full");
    end
    for (int i = 0; i < 16; i++) do_cycle(1'b0, '0, 1'b1);
    check_state("drained");

    // Long stream across several pointer wraps.
    for (int i = 0; i < 40; i++)
      do_cycle(1'b1, 32'hC000_0000 + 32'(i), (i % 3) != 0);
    while (sb_q.size() > 0) do_cycle(1'b0, '0, 1'b1);

    // Mid-operation reset discards contents.
    for (int i = 0; i < 3; i++) do_cycle(1'b1, 32'hD000_0000 + 32'(i), 1'b0);
    rst = 1'b1;
    #1;
    check_eq("midrst_dout", dout, 32'h0);
    check_eq("midrst_count", 32'(dut.count_reg), 32'h0);
    sb_q.delete();
    model_dout = '0;
    model_rd   = 0;
    model_wr   = 0;
    @(posedge clk);
    #1 rst = 1'b0;
    do_cycle(1'b0, '0, 1'b1);
    check_eq("postrst_empty", dout, 32'h0);
    do_cycle(1'b1, 32'h77, 1'b0);
    do_cycle(1'b0, '0, 1'b1);
    check_state("postrst");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
